// File: rtl/smpl_source.sv
// Producer end of the clkSmpl sample stream: decimates raw ADC codes, waits for a
// level-crossing (or timeout) trigger, then streams one marked frame while smpl_req is held.
module smpl_source #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned TO_W  = 20
) (
  input  logic             clkSmpl,
  input  logic             n_reset,
  input  logic             adc_valid,
  input  logic [DW-1:0]    adc_data,
  input  logic [DIV_W-1:0] div,
  input  logic [DW-1:0]    trig_level,
  input  logic             trig_edge,
  input  logic             trig_auto,
  input  logic [TO_W-1:0]  trig_timeout,
  input  logic             smpl_req,
  output logic             smpl_valid,
  output logic [15:0]      smpl,
  output logic             triggered,
  output logic             forced
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t           state;

  // Frame configuration, frozen for the whole frame at arm time
  logic [DIV_W-1:0] div_q;
  logic [DW-1:0]    level_q;
  logic             edge_q;
  logic             auto_q;
  logic [TO_W-1:0]  timeout_q;

  logic [DIV_W-1:0] dcnt;
  logic [TO_W-1:0]  tcnt;
  logic [DW-1:0]    prev;
  logic             have_prev;

  logic dvalid_c;
  logic rise_c;
  logic fall_c;
  logic edge_hit_c;
  logic timeout_hit_c;
  logic trig_c;

  // Decimated sample strobe and trigger qualification on the incoming code
  assign dvalid_c      = (state != IDLE) && adc_valid && (dcnt == div_q);
  assign rise_c        = have_prev && (prev < level_q) && (adc_data >= level_q);
  assign fall_c        = have_prev && (prev > level_q) && (adc_data <= level_q);
  assign edge_hit_c    = edge_q ? fall_c : rise_c;
  assign timeout_hit_c = auto_q && (tcnt == timeout_q);
  assign trig_c        = (state == ARM) && dvalid_c && (edge_hit_c || timeout_hit_c);

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      div_q      <= '0;
      level_q    <= '0;
      edge_q     <= 1'b0;
      auto_q     <= 1'b0;
      timeout_q  <= '0;
      dcnt       <= '0;
      tcnt       <= '0;
      prev       <= '0;
      have_prev  <= 1'b0;
      smpl_valid <= 1'b0;
      smpl       <= '0;
      triggered  <= 1'b0;
      forced     <= 1'b0;
    end else begin
      smpl_valid <= 1'b0;

      // Decimation counter only advances on valid codes while armed or streaming
      if ((state != IDLE) && adc_valid) begin
        if (dcnt == div_q) begin
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DIV_W'(1);
        end
      end

      case (state)
        IDLE: begin
          triggered <= 1'b0;
          if (smpl_req) begin
            state     <= ARM;
            div_q     <= div;
            level_q   <= trig_level;
            edge_q    <= trig_edge;
            auto_q    <= trig_auto;
            timeout_q <= trig_timeout;
            dcnt      <= '0;
            tcnt      <= '0;
            have_prev <= 1'b0;
            forced    <= 1'b0;
          end
        end

        ARM: begin
          if (dvalid_c) begin
            prev      <= adc_data;
            have_prev <= 1'b1;
            if (tcnt != '1) begin
              tcnt <= tcnt + TO_W'(1);
            end
          end
          // A triggering sample is emitted even when smpl_req drops in the same cycle
          if (trig_c) begin
            smpl_valid <= 1'b1;
            smpl       <= {1'b1, adc_data, 3'b000};
            triggered  <= smpl_req;
            forced     <= !edge_hit_c;
          end
          if (!smpl_req) begin
            state <= IDLE;
          end else if (trig_c) begin
            state <= STREAM;
          end
        end

        STREAM: begin
          if (dvalid_c) begin
            smpl_valid <= 1'b1;
            smpl       <= {1'b0, adc_data, 3'b000};
          end
          if (!smpl_req) begin
            state     <= IDLE;
            triggered <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          triggered <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smpl_source.sv
// Scoreboard bench for smpl_source: stimulus pushes hand-computed samples with their
// expected arrival cycle; a negedge monitor pops and compares every emitted sample.
`timescale 1ns/1ps
module tb_smpl_source;

  logic        clkSmpl = 1'b0;
  logic        n_reset;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [15:0] div;
  logic [11:0] trig_level;
  logic        trig_edge;
  logic        trig_auto;
  logic [19:0] trig_timeout;
  logic        smpl_req;
  logic        smpl_valid;
  logic [15:0] smpl;
  logic        triggered;
  logic        forced;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  smpl_source dut (
    .clkSmpl      (clkSmpl),
    .n_reset      (n_reset),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .div          (div),
    .trig_level   (trig_level),
    .trig_edge    (trig_edge),
    .trig_auto    (trig_auto),
    .trig_timeout (trig_timeout),
    .smpl_req     (smpl_req),
    .smpl_valid   (smpl_valid),
    .smpl         (smpl),
    .triggered    (triggered),
    .forced       (forced)
  );

  always #5 clkSmpl = ~clkSmpl;
  always @(posedge clkSmpl) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic cfg(input logic [15:0] d, input logic [11:0] lvl, input logic edg,
                     input logic aut, input logic [19:0] tmo);
    div          = d;
    trig_level   = lvl;
    trig_edge    = edg;
    trig_auto    = aut;
    trig_timeout = tmo;
  endtask

  // One cycle of ADC input; optionally queue the sample expected one cycle later
  task automatic adc(input logic v, input logic [11:0] d, input logic ev, input logic [15:0] ed);
    exp_t e;
    adc_valid = v;
    adc_data  = d;
    if (ev) begin
      e.data = ed;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clkSmpl);
    #1;
  endtask

  // Monitor: every emitted sample must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clkSmpl);
      if (n_reset && smpl_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_smpl: got %h at cycle %0d, expected no sample", smpl, cyc);
        end else begin
          e = exp_q.pop_front();
          if (smpl !== e.data || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL smpl: got %h at cycle %0d, expected %h at cycle %0d",
                     smpl, cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp2 [4];
    exp2 = '{16'h8018, 16'h0038, 16'h0058, 16'h0078};

    n_reset   = 1'b0;
    smpl_req  = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    cfg(16'd0, 12'h000, 1'b0, 1'b0, 20'd0);
    repeat (2) @(posedge clkSmpl);
    #1;
    check("reset_smpl_valid", 32'(smpl_valid), 32'd0);
    check("reset_smpl", 32'(smpl), 32'd0);
    check("reset_triggered", 32'(triggered), 32'd0);
    check("reset_forced", 32'(forced), 32'd0);
    n_reset = 1'b1;
    @(posedge clkSmpl);
    #1;

    // Rising edge through 0x800, no decimation
    cfg(16'd0, 12'h800, 1'b0, 1'b0, 20'd0);
    smpl_req = 1'b1;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);
    adc(1'b1, 12'h7F0, 1'b0, 16'h0000);
    adc(1'b1, 12'h7F8, 1'b0, 16'h0000);
    adc(1'b1, 12'h800, 1'b1, 16'hC000);
    adc(1'b1, 12'h808, 1'b1, 16'h4040);
    check("t1_triggered", 32'(triggered), 32'd1);
    check("t1_forced", 32'(forced), 32'd0);
    smpl_req = 1'b0;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);
    check("t1_triggered_drop", 32'(triggered), 32'd0);

    // Decimation by 4 with immediate forced trigger
    cfg(16'd3, 12'h800, 1'b0, 1'b1, 20'd0);
    smpl_req = 1'b1;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      adc(1'b1, 12'(i), (i % 4) == 3, exp2[i / 4]);
    end
    check("t2_forced", 32'(forced), 32'd1);
    check("t2_triggered", 32'(triggered), 32'd1);
    smpl_req = 1'b0;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);

    // Falling edge across an input gap
    cfg(16'd0, 12'h400, 1'b1, 1'b0, 20'd0);
    smpl_req = 1'b1;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);
    adc(1'b1, 12'h500, 1'b0, 16'h0000);
    repeat (5) adc(1'b0, 12'h000, 1'b0, 16'h0000);
    adc(1'b1, 12'h3FF, 1'b1, 16'h9FF8);
    check("t3_forced", 32'(forced), 32'd0);
    check("t3_triggered", 32'(triggered), 32'd1);
    smpl_req = 1'b0;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);

    // Auto timeout after 4 silent dvalids
    cfg(16'd0, 12'h800, 1'b0, 1'b1, 20'd4);
    smpl_req = 1'b1;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);
    repeat (4) adc(1'b1, 12'h100, 1'b0, 16'h0000);
    adc(1'b1, 12'h100, 1'b1, 16'h8800);
    adc(1'b1, 12'h100, 1'b1, 16'h0800);
    check("t4_forced", 32'(forced), 32'd1);
    smpl_req = 1'b0;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);

    // One-cycle req drop re-arms with new configuration
    cfg(16'd0, 12'h800, 1'b0, 1'b0, 20'd0);
    smpl_req = 1'b1;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);
    adc(1'b1, 12'h700, 1'b0, 16'h0000);
    adc(1'b1, 12'h900, 1'b1, 16'hC800);
    adc(1'b1, 12'h900, 1'b1, 16'h4800);
    smpl_req = 1'b0;
    adc(1'b1, 12'h910, 1'b1, 16'h4880);
    check("t5_triggered_drop", 32'(triggered), 32'd0);
    cfg(16'd1, 12'h600, 1'b0, 1'b0, 20'd0);
    smpl_req = 1'b1;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);
    adc(1'b1, 12'h500, 1'b0, 16'h0000);
    adc(1'b1, 12'h500, 1'b0, 16'h0000);
    adc(1'b1, 12'h700, 1'b0, 16'h0000);
    adc(1'b1, 12'h700, 1'b1, 16'hB800);
    check("t5_retriggered", 32'(triggered), 32'd1);
    check("t5_forced", 32'(forced), 32'd0);

    // Asynchronous reset while a sample is on the output
    cfg(16'd0, 12'h800, 1'b0, 1'b0, 20'd0);
    adc(1'b1, 12'h720, 1'b0, 16'h0000);
    adc_valid = 1'b1;
    adc_data  = 12'h720;
    @(posedge clkSmpl);
    #1;
    adc_valid = 1'b0;
    check("t6_pre_valid", 32'(smpl_valid), 32'd1);
    check("t6_pre_smpl", 32'(smpl), 32'h3900);
    n_reset = 1'b0;
    #1;
    check("t6_rst_smpl_valid", 32'(smpl_valid), 32'd0);
    check("t6_rst_smpl", 32'(smpl), 32'd0);
    check("t6_rst_triggered", 32'(triggered), 32'd0);
    check("t6_rst_forced", 32'(forced), 32'd0);
    @(negedge clkSmpl);
    n_reset = 1'b1;
    @(posedge clkSmpl);
    #1;
    adc(1'b1, 12'h700, 1'b0, 16'h0000);
    adc(1'b1, 12'h900, 1'b1, 16'hC800);
    check("t6_rearm_triggered", 32'(triggered), 32'd1);
    check("t6_rearm_forced", 32'(forced), 32'd0);
    smpl_req = 1'b0;
    adc(1'b0, 12'h000, 1'b0, 16'h0000);

    repeat (3) @(posedge clkSmpl);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/smpl_source.md
Name: smpl_source

Overview:
- Producer end of the clkSmpl sample-stream handshake (smpl_req / smpl_valid / smpl[15:0]).
- Takes raw ADC codes, decimates them, waits for a trigger, then streams one triggered frame to a display consumer for as long as the consumer holds smpl_req.
- The first sample of every frame carries a marker bit. Consumers that buffer smpl[14:3] therefore always start on a trigger-aligned sample.

Parameters:
- DW, 12, ADC code width; fixed at 12 because smpl[14:3] carries it.
- DIV_W, 16, width of the decimation divisor.
- TO_W, 20, width of the auto-trigger timeout counter.

Ports:
- clkSmpl  in  1  sample clock; all logic on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- adc_valid  in  1  adc_data valid this cycle.
- adc_data  in  DW  unsigned ADC code.
- div  in  DIV_W  emit one sample per div+1 valid ADC codes.
- trig_level  in  DW  trigger threshold.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_auto  in  1  force a trigger after the timeout.
- trig_timeout  in  TO_W  decimated samples to wait before the forced trigger.
- smpl_req  in  1  consumer wants samples; level, may drop at any cycle.
- smpl_valid  out  1  smpl holds a sample; one-cycle pulse per sample.
- smpl  out  16  {marker, code[11:0], 3'b000}.
- triggered  out  1  high while streaming a frame.
- forced  out  1  current or last frame was started by timeout, not by an edge.

Behaviour:
- Reset values: smpl_valid = 0, smpl = 0, triggered = 0, forced = 0, state = Idle, all counters = 0.
- Decimator:
  - dcnt counts adc_valid cycles only, outside Idle.
  - A decimated sample (dvalid, dcode = adc_data) is produced when dcnt == div; dcnt then returns to 0, otherwise it increments.
  - div = 0 passes every valid code through.
  - dcnt is cleared on entry to Arm.
- Config latch: div, trig_level, trig_edge, trig_auto and trig_timeout are registered on the Idle->Arm transition. Changes during a frame have no effect until the next arm.
- State Idle:
  - smpl_valid = 0.
  - smpl_req = 1 -> Arm; clear have_prev, tcnt and forced.
- State Arm, waiting for trigger:
  - On each dvalid, compare against prev, the previous decimated code.
  - Rising edge: have_prev && prev < level && dcode >= level.
  - Falling edge: have_prev && prev > level && dcode <= level.
  - Forced trigger: trig_auto && tcnt == timeout, where tcnt is the number of dvalids already seen in Arm (the first dvalid sees tcnt = 0).
  - On any dvalid: prev <= dcode, have_prev <= 1, tcnt <= tcnt + 1 (saturating).
  - On an edge or forced trigger in the same dvalid -> Stream. This sample is emitted as the first of the frame with smpl[15] = 1. forced <= 1 only if the edge condition was false.
  - trig_auto = 0 -> wait indefinitely.
  - trig_timeout = 0 with auto -> the first dvalid triggers.
- State Stream:
  - Every dvalid is emitted with smpl[15] = 0.
  - triggered = 1 from the cycle the first frame sample is emitted.
- Output latency: smpl_valid/smpl are registered, asserted exactly one clkSmpl cycle after the adc_valid cycle that produced the dvalid. smpl holds its value until the next emitted sample.
- Handshake:
  - A transfer occurs on any cycle with smpl_valid && smpl_req.
  - There is no stall. The producer never holds a sample waiting for acceptance.
  - Samples emitted while the consumer's FIFO is full are lost by design; the consumer deasserts smpl_req to end the frame.
- smpl_req drop:
  - In Arm or Stream, smpl_req = 0 -> Idle on the next edge; triggered <= 0.
  - A dvalid in that same cycle is still emitted, with a marker only if it triggers. It is harmless because the consumer gates on smpl_req.
  - smpl_req low for a single cycle still forces a full re-arm.
- smpl_req rising in the same cycle as adc_valid in Idle: that code is not counted; decimation starts on the next adc_valid.
- Counter widths: tcnt saturates at all-ones and never wraps. dcnt is DIV_W bits and never exceeds div.
- Reset mid-frame: immediate return to the reset values, asynchronously. No partial frame resumes.

Test Plan:
- Rising edge, div = 0, level = 0x800, edge = 0, auto = 0; req = 1; ramp codes 0x7F0, 0x7F8, 0x800, 0x808 one per cycle -> first smpl_valid carries smpl = {1, 0x800, 000} = 0x8000 | (0x800 << 3), one cycle after the 0x800 input; the 0x808 sample follows with marker 0; triggered = 1.
- Decimation, div = 3, 16 valid codes 0..15 after arm, auto = 1, timeout = 0 -> outputs are codes 3, 7, 11, 15 only, first marked; forced = 1.
- Falling edge with gaps, edge = 1, level = 0x400; codes 0x500, (adc_valid low 5 cycles), 0x3FF -> marker on 0x3FF; no output during the gap.
- Auto timeout, auto = 1, timeout = 4, constant code 0x100, level = 0x800 -> the 5th dvalid is emitted with marker; forced = 1; no output for dvalids 1-4.
- Req drop: in Stream, smpl_req = 0 for one cycle then 1; next crossing of level 0x800 -> triggered drops to 0, the next frame's first sample is re-marked, and config changes made meanwhile take effect.
- Reset mid-Stream: n_reset low asynchronously -> smpl_valid, smpl, triggered and forced = 0 immediately; after release with req = 1 the block re-arms from Idle.
